// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational off registered state; updates arrive from EX on the rising edge.
module branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 6,
  parameter int CTR_BITS   = 2,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_npc,
  output logic                  pred_hit,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic                  upd_mispredict,
  input  logic                  flush,
  output logic [PERF_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [CTR_BITS-1:0]   ctr_inc;
  logic [CTR_BITS-1:0]   ctr_dec;

  // Only the index/tag fields of upd_pc address the table; the rest is intentionally ignored.
  logic unused_upd_pc;
  assign unused_upd_pc = ^upd_pc;

  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign lookup_tag = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign upd_idx    = upd_pc[INDEX_BITS+1:2];
  assign upd_tag    = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  assign pred_hit   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign pred_taken = pred_hit && ctr_q[lookup_idx][CTR_BITS-1];
  assign pred_npc   = pred_taken ? target_q[lookup_idx] : lookup_pc + PC_WIDTH'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr = ctr_q[upd_idx];

  always_comb begin
    ctr_inc = upd_ctr;
    ctr_dec = upd_ctr;
    if (upd_ctr != CTR_MAX) ctr_inc = upd_ctr + CTR_BITS'(1);
    if (upd_ctr != CTR_ZERO) ctr_dec = upd_ctr - CTR_BITS'(1);
  end

  // Flush takes priority over a same-cycle update; a not-taken miss leaves the table alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= ctr_inc;
          target_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx] <= ctr_dec;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= CTR_WEAK;
      end
    end
  end

  // Counts independently of flush and saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_count <= '0;
    end else if (upd_valid && upd_mispredict && (mispredict_count != PERF_MAX)) begin
      mispredict_count <= mispredict_count + PERF_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; a second instance with a
// 2-bit performance counter shares all inputs to exercise counter saturation.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        flush;
  logic [31:0] mispredict_count;

  logic        s_pred_taken;
  logic [31:0] s_pred_npc;
  logic        s_pred_hit;
  logic [1:0]  s_mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_npc(pred_npc), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
    .mispredict_count(mispredict_count)
  );

  branch_predictor #(.PERF_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(s_pred_taken), .pred_npc(s_pred_npc), .pred_hit(s_pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .flush(flush),
    .mispredict_count(s_mispredict_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid      = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_mispredict = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    lookup_pc = 32'h8000;
    #1;
    checks++;
    if (pred_hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %0b expected 0", pred_hit); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken: got %0b expected 0", pred_taken); end
    checks++;
    if (pred_npc !== 32'h8004) begin errors++; $display("[TB] FAIL reset_npc: got %h expected 00008004", pred_npc); end
    checks++;
    if (mispredict_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", mispredict_count); end
    lookup_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (pred_npc !== 32'h0) begin errors++; $display("[TB] FAIL npc_wrap: got %h expected 00000000", pred_npc); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_allocate();
    do_update(32'h8010, 1'b1, 32'h8100);
    lookup_pc = 32'h8010;
    #1;
    checks++;
    if ({pred_hit, pred_taken} !== 2'b11) begin errors++; $display("[TB] FAIL alloc_hit_taken: got %b expected 11", {pred_hit, pred_taken}); end
    checks++;
    if (pred_npc !== 32'h8100) begin errors++; $display("[TB] FAIL alloc_npc: got %h expected 00008100", pred_npc); end
    lookup_pc = 32'h8014;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_npc !== 32'h8018) begin errors++; $display("[TB] FAIL alloc_neighbour: got hit=%0b npc=%h expected hit=0 npc=00008018", pred_hit, pred_npc); end
  endtask

  task automatic test_counter();
    lookup_pc = 32'h8010;
    do_update(32'h8010, 1'b0, 32'h0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_npc !== 32'h8014) begin errors++; $display("[TB] FAIL ctr_1: got hit=%0b taken=%0b npc=%h expected 1 0 00008014", pred_hit, pred_taken, pred_npc); end
    do_update(32'h8010, 1'b0, 32'h0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10 || pred_npc !== 32'h8014) begin errors++; $display("[TB] FAIL ctr_0: got hit=%0b taken=%0b npc=%h expected 1 0 00008014", pred_hit, pred_taken, pred_npc); end
    for (int i = 0; i < 4; i++) do_update(32'h8010, 1'b1, 32'h8200);
    checks++;
    if (pred_taken !== 1'b1 || pred_npc !== 32'h8200) begin errors++; $display("[TB] FAIL ctr_sat: got taken=%0b npc=%h expected 1 00008200", pred_taken, pred_npc); end
    do_update(32'h8010, 1'b0, 32'h0);
    checks++;
    if (pred_taken !== 1'b1 || pred_npc !== 32'h8200) begin errors++; $display("[TB] FAIL ctr_3to2: got taken=%0b npc=%h expected 1 00008200", pred_taken, pred_npc); end
    do_update(32'h8010, 1'b0, 32'h0);
    checks++;
    if ({pred_hit, pred_taken} !== 2'b10) begin errors++; $display("[TB] FAIL ctr_2to1: got hit=%0b taken=%0b expected 1 0", pred_hit, pred_taken); end
  endtask

  task automatic test_aliasing();
    do_update(32'h8010, 1'b1, 32'h8100);
    do_update(32'h8410, 1'b1, 32'h9000);
    lookup_pc = 32'h8010;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_npc !== 32'h8014) begin errors++; $display("[TB] FAIL alias_evicted: got hit=%0b npc=%h expected 0 00008014", pred_hit, pred_npc); end
    lookup_pc = 32'h8410;
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_npc !== 32'h9000) begin errors++; $display("[TB] FAIL alias_new: got hit=%0b npc=%h expected 1 00009000", pred_hit, pred_npc); end
    do_update(32'h8810, 1'b0, 32'h0);
    checks++;
    if (pred_hit !== 1'b1 || pred_npc !== 32'h9000) begin errors++; $display("[TB] FAIL alias_nt_miss: got hit=%0b npc=%h expected 1 00009000", pred_hit, pred_npc); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    do_update(32'h8020, 1'b1, 32'hA000);
    lookup_pc = 32'h8410;
    #1;
    checks++;
    if (pred_hit !== 1'b0) begin errors++; $display("[TB] FAIL flush_old: got hit=%0b expected 0", pred_hit); end
    lookup_pc = 32'h8020;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_npc !== 32'h8024) begin errors++; $display("[TB] FAIL flush_wins: got hit=%0b npc=%h expected 0 00008024", pred_hit, pred_npc); end
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 3; i++) begin
      upd_mispredict = 1'b1;
      do_update(32'h8F00, 1'b0, 32'h0);
    end
    checks++;
    if (mispredict_count !== 32'd3) begin errors++; $display("[TB] FAIL mp_count3: got %0d expected 3", mispredict_count); end
    upd_valid = 1'b0; upd_mispredict = 1'b1;
    tick();
    idle();
    checks++;
    if (mispredict_count !== 32'd3) begin errors++; $display("[TB] FAIL mp_no_valid: got %0d expected 3", mispredict_count); end
    flush = 1'b1; upd_mispredict = 1'b1;
    do_update(32'h8F00, 1'b0, 32'h0);
    checks++;
    if (mispredict_count !== 32'd4) begin errors++; $display("[TB] FAIL mp_flush_cycle: got %0d expected 4", mispredict_count); end
  endtask

  task automatic test_back_to_back();
    lookup_pc  = 32'h8030;
    upd_valid  = 1'b1;
    upd_pc     = 32'h8030;
    upd_taken  = 1'b1;
    upd_target = 32'hA000;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_npc !== 32'h8034) begin errors++; $display("[TB] FAIL same_cycle_pre: got hit=%0b npc=%h expected 0 00008034", pred_hit, pred_npc); end
    tick();
    idle();
    checks++;
    if (pred_hit !== 1'b1 || pred_npc !== 32'hA000) begin errors++; $display("[TB] FAIL same_cycle_post: got hit=%0b npc=%h expected 1 0000a000", pred_hit, pred_npc); end
    upd_valid = 1'b0; upd_pc = 'x; upd_taken = 'x; upd_target = 'x; upd_mispredict = 'x;
    tick();
    idle();
    checks++;
    if (pred_hit !== 1'b1 || pred_npc !== 32'hA000 || mispredict_count !== 32'd4) begin errors++; $display("[TB] FAIL x_inputs: got hit=%0b npc=%h cnt=%0d expected 1 0000a000 4", pred_hit, pred_npc, mispredict_count); end
  endtask

  task automatic test_async_reset();
    upd_valid = 1'b1; upd_pc = 32'h8040; upd_taken = 1'b1; upd_target = 32'hB000;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_npc !== 32'h8034 || mispredict_count !== 32'd0) begin errors++; $display("[TB] FAIL async_reset: got hit=%0b npc=%h cnt=%0d expected 0 00008034 0", pred_hit, pred_npc, mispredict_count); end
    tick();
    rst = 1'b0;
    idle();
    lookup_pc = 32'h8040;
    tick();
    checks++;
    if (pred_hit !== 1'b0 || pred_npc !== 32'h8044) begin errors++; $display("[TB] FAIL reset_mid_update: got hit=%0b npc=%h expected 0 00008044", pred_hit, pred_npc); end
  endtask

  task automatic test_perf_saturate();
    for (int i = 0; i < 2; i++) begin
      upd_mispredict = 1'b1;
      do_update(32'h8F00, 1'b0, 32'h0);
    end
    checks++;
    if (s_mispredict_count !== 2'd2) begin errors++; $display("[TB] FAIL perf_small_2: got %0d expected 2", s_mispredict_count); end
    for (int i = 0; i < 3; i++) begin
      upd_mispredict = 1'b1;
      do_update(32'h8F00, 1'b0, 32'h0);
    end
    checks++;
    if (s_mispredict_count !== 2'd3) begin errors++; $display("[TB] FAIL perf_small_sat: got %0d expected 3", s_mispredict_count); end
    checks++;
    if (mispredict_count !== 32'd5) begin errors++; $display("[TB] FAIL perf_wide_5: got %0d expected 5", mispredict_count); end
    checks++;
    if (s_pred_hit !== pred_hit || s_pred_npc !== pred_npc || s_pred_taken !== pred_taken) begin errors++; $display("[TB] FAIL small_lookup: got hit=%0b npc=%h expected hit=%0b npc=%h", s_pred_hit, s_pred_npc, pred_hit, pred_npc); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter();
    test_aliasing();
    test_flush();
    test_mispredict();
    test_back_to_back();
    test_async_reset();
    test_perf_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
